// File: rtl/lgv8_multicycle_core.sv
// Multi-cycle LEGv8 core (ADD/SUB/AND/ORR/LDUR/STUR/CBZ/B) with one unified req/ready memory port.
// Define LGV8_PERF_CNT_EN to add the cycle_cnt/instret_cnt performance counter outputs.
module lgv8_multicycle_core #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset_n,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] writedata,
    output logic            retire,
    output logic            halted
`ifdef LGV8_PERF_CNT_EN
    ,
    output logic [31:0]     cycle_cnt,
    output logic [31:0]     instret_cnt
`endif
);

    localparam logic [2:0] StFetch  = 3'd0;
    localparam logic [2:0] StDecode = 3'd1;
    localparam logic [2:0] StExec   = 3'd2;
    localparam logic [2:0] StMem    = 3'd3;
    localparam logic [2:0] StWb     = 3'd4;
    localparam logic [2:0] StHalt   = 3'd5;

    localparam logic [2:0] KindR    = 3'd0;
    localparam logic [2:0] KindLdur = 3'd1;
    localparam logic [2:0] KindStur = 3'd2;
    localparam logic [2:0] KindCbz  = 3'd3;
    localparam logic [2:0] KindB    = 3'd4;

    localparam logic [10:0] OpcAdd  = 11'b10001011000;
    localparam logic [10:0] OpcSub  = 11'b11001011000;
    localparam logic [10:0] OpcAnd  = 11'b10001010000;
    localparam logic [10:0] OpcOrr  = 11'b10101010000;
    localparam logic [10:0] OpcLdur = 11'b11111000010;
    localparam logic [10:0] OpcStur = 11'b11111000000;
    localparam logic [7:0]  OpcCbz  = 8'b10110100;
    localparam logic [5:0]  OpcB    = 6'b000101;

    logic [2:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] writedata_q, writedata_d;
    logic            retire_q, retire_d;
    logic [XLEN-1:0] rf_q [32];
    logic            rf_we;

    logic [XLEN-1:0] rn_val, rm_val, rt_val, alu_res;
    logic [XLEN-1:0] imm9, imm19, imm26;
    logic            is_rtype;

    // X31 is XZR: never written and always read as zero.
    assign rn_val = (ir_q[9:5] == 5'd31) ? '0 : rf_q[ir_q[9:5]];
    assign rm_val = (ir_q[20:16] == 5'd31) ? '0 : rf_q[ir_q[20:16]];
    assign rt_val = (ir_q[4:0] == 5'd31) ? '0 : rf_q[ir_q[4:0]];

    assign imm9  = {{(XLEN-9){ir_q[20]}}, ir_q[20:12]};
    assign imm19 = {{(XLEN-21){ir_q[23]}}, ir_q[23:5], 2'b00};
    assign imm26 = {{(XLEN-28){ir_q[25]}}, ir_q[25:0], 2'b00};

    assign is_rtype = (ir_q[31:21] == OpcAdd) || (ir_q[31:21] == OpcSub) ||
                      (ir_q[31:21] == OpcAnd) || (ir_q[31:21] == OpcOrr);

    always_comb begin
        alu_res = '0;
        case (ir_q[31:21])
            OpcAdd:  alu_res = a_q + b_q;
            OpcSub:  alu_res = a_q - b_q;
            OpcAnd:  alu_res = a_q & b_q;
            OpcOrr:  alu_res = a_q | b_q;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        addr_d      = addr_q;
        result_d    = result_q;
        op_d        = op_q;
        writedata_d = writedata_q;
        retire_d    = 1'b0;
        rf_we       = 1'b0;
        case (state_q)
            StFetch: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata[31:0];
                    state_d = StDecode;
                end
            end
            StDecode: begin
                a_d     = rn_val;
                state_d = StExec;
                if (is_rtype) begin
                    op_d = KindR;
                    b_d  = rm_val;
                end else if (ir_q[31:21] == OpcLdur) begin
                    op_d = KindLdur;
                end else if (ir_q[31:21] == OpcStur) begin
                    op_d = KindStur;
                    b_d  = rt_val;
                end else if (ir_q[31:24] == OpcCbz) begin
                    op_d = KindCbz;
                    b_d  = rt_val;
                end else if (ir_q[31:26] == OpcB) begin
                    op_d = KindB;
                end else begin
                    state_d = StHalt;
                end
            end
            StExec: begin
                case (op_q)
                    KindR: begin
                        result_d = alu_res;
                        state_d  = StWb;
                    end
                    KindLdur, KindStur: begin
                        addr_d  = a_q + imm9;
                        state_d = StMem;
                    end
                    KindCbz: begin
                        pc_d     = (b_q == '0) ? pc_q + imm19 : pc_q + XLEN'(4);
                        retire_d = 1'b1;
                        state_d  = StFetch;
                    end
                    default: begin
                        pc_d     = pc_q + imm26;
                        retire_d = 1'b1;
                        state_d  = StFetch;
                    end
                endcase
            end
            StMem: begin
                if (mem_ready) begin
                    if (op_q == KindStur) begin
                        pc_d     = pc_q + XLEN'(4);
                        retire_d = 1'b1;
                        state_d  = StFetch;
                    end else begin
                        result_d = mem_rdata;
                        state_d  = StWb;
                    end
                end
            end
            StWb: begin
                rf_we       = (ir_q[4:0] != 5'd31);
                writedata_d = result_q;
                pc_d        = pc_q + XLEN'(4);
                retire_d    = 1'b1;
                state_d     = StFetch;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StFetch;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            addr_q      <= '0;
            result_q    <= '0;
            op_q        <= KindR;
            writedata_q <= '0;
            retire_q    <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            addr_q      <= addr_d;
            result_q    <= result_d;
            op_q        <= op_d;
            writedata_q <= writedata_d;
            retire_q    <= retire_d;
            if (rf_we) begin
                rf_q[ir_q[4:0]] <= result_q;
            end
        end
    end

    // Request is gated by reset_n so an in-flight access drops as soon as reset asserts.
    assign mem_req   = reset_n && ((state_q == StFetch) || (state_q == StMem));
    assign mem_we    = mem_req && (state_q == StMem) && (op_q == KindStur);
    assign mem_addr  = !mem_req ? '0 : ((state_q == StMem) ? addr_q : pc_q);
    assign mem_wdata = mem_we ? b_q : '0;
    assign pc        = pc_q;
    assign writedata = writedata_q;
    assign retire    = retire_q;
    assign halted    = (state_q == StHalt);

`ifdef LGV8_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, instret_cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            if (state_q != StHalt) begin
                cycle_cnt_q <= cycle_cnt_q + 32'd1;
            end
            if (retire_d) begin
                instret_cnt_q <= instret_cnt_q + 32'd1;
            end
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_lgv8_multicycle_core.sv
// Scoreboard bench for lgv8_multicycle_core: programs run against a behavioural memory with
// configurable wait states; retire and store events are checked against queued expectations.
module tb_lgv8_multicycle_core;

    localparam logic [10:0] OpcAdd  = 11'b10001011000;
    localparam logic [10:0] OpcSub  = 11'b11001011000;
    localparam logic [10:0] OpcAnd  = 11'b10001010000;
    localparam logic [10:0] OpcOrr  = 11'b10101010000;
    localparam logic [10:0] OpcLdur = 11'b11111000010;
    localparam logic [10:0] OpcStur = 11'b11111000000;
    localparam logic [31:0] Illegal = 32'hFFFF_FFFF;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        mem_req, mem_we, mem_ready;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [63:0] pc, writedata;
    logic        retire, halted;
`ifdef LGV8_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    lgv8_multicycle_core #(
        .XLEN     (64),
        .RESET_PC (64'h0)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .pc        (pc),
        .writedata (writedata),
        .retire    (retire),
        .halted    (halted)
`ifdef LGV8_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] wd;
        int          lat;
    } retire_exp_t;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
    } store_exp_t;

    retire_exp_t sb[$];
    store_exp_t  sq[$];
    logic [63:0] mem [logic [63:0]];

    int n_checks = 0;
    int n_pass   = 0;
    int wait_n   = 0;
    int cyc      = 0;
    int last_ret = 0;
    int n_ret    = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] enc_r(input logic [10:0] opc, input logic [4:0] rd,
                                          input logic [4:0] rn, input logic [4:0] rm);
        return {opc, rm, 6'd0, rn, rd};
    endfunction

    function automatic logic [31:0] enc_m(input logic [10:0] opc, input logic [4:0] rt,
                                          input logic [4:0] rn, input logic [8:0] imm);
        return {opc, imm, 2'b00, rn, rt};
    endfunction

    function automatic logic [31:0] enc_cbz(input logic [4:0] rt, input logic [18:0] imm);
        return {8'b10110100, imm, rt};
    endfunction

    function automatic logic [31:0] enc_b(input logic [25:0] imm);
        return {6'b000101, imm};
    endfunction

    task automatic put_ins(input logic [63:0] addr, input logic [31:0] word);
        mem[addr] = {32'h0, word};
    endtask

    task automatic push_ret(input logic [63:0] npc, input logic [63:0] wd, input int lat);
        retire_exp_t e;
        e.pc = npc; e.wd = wd; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic push_store(input logic [63:0] addr, input logic [63:0] data);
        store_exp_t s;
        s.addr = addr; s.data = data;
        sq.push_back(s);
    endtask

    // Cycle count since reset release; one increment per rising edge.
    always @(posedge clock) begin
        if (!reset_n) cyc = 0;
        else cyc++;
    end

    // Memory responder: raises ready after wait_n cycles of a pending request.
    int          cnt = 0;
    logic        hold_we, done_we;
    logic [63:0] hold_addr, hold_wd, done_addr, done_wd;
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
    end
    always @(negedge clock) begin
        store_exp_t st;
        if (!reset_n) begin
            cnt       = 0;
            mem_ready = 1'b0;
        end else begin
            if (mem_ready) begin
                if (done_we) begin
                    if (sq.size() == 0) begin
                        check_eq("store_unexpected", 64'(sq.size()), 64'd1);
                    end else begin
                        st = sq.pop_front();
                        check_eq("store_addr", done_addr, st.addr);
                        check_eq("store_data", done_wd, st.data);
                    end
                    mem[done_addr] = done_wd;
                end
                cnt = 0;
            end
            mem_ready = 1'b0;
            if (mem_req) begin
                if (cnt == 0) begin
                    hold_addr = mem_addr;
                    hold_we   = mem_we;
                    hold_wd   = mem_wdata;
                end else begin
                    check_eq("hold_addr", mem_addr, hold_addr);
                    check_eq("hold_we", 64'(mem_we), 64'(hold_we));
                    check_eq("hold_wdata", mem_wdata, hold_wd);
                end
                if (cnt >= wait_n) begin
                    mem_ready = 1'b1;
                    done_we   = mem_we;
                    done_addr = mem_addr;
                    done_wd   = mem_wdata;
                    mem_rdata = (!mem_we && mem.exists(mem_addr)) ? mem[mem_addr] : '0;
                end
                cnt++;
            end
        end
    end

    // Retire monitor: each pulse pops one expectation.
    always @(negedge clock) begin
        retire_exp_t e;
        if (!reset_n) begin
            n_ret    = 0;
            last_ret = 0;
        end else if (retire) begin
            n_ret++;
            if (sb.size() == 0) begin
                check_eq("retire_unexpected", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                check_eq("retire_pc", pc, e.pc);
                check_eq("retire_writedata", writedata, e.wd);
                check_eq("retire_latency", 64'(cyc - last_ret), 64'(e.lat));
                last_ret = cyc;
`ifdef LGV8_PERF_CNT_EN
                check_eq("instret_cnt", 64'(instret_cnt), 64'(n_ret));
                check_eq("cycle_cnt", 64'(cycle_cnt), 64'(cyc));
`endif
            end
        end
    end

    task automatic do_reset();
        @(posedge clock);
        #2 reset_n = 1'b0;
        @(posedge clock);
        #1;
        check_eq("rst_pc", pc, 64'h0);
        check_eq("rst_mem_req", 64'(mem_req), 64'd0);
        check_eq("rst_mem_we", 64'(mem_we), 64'd0);
        check_eq("rst_mem_addr", mem_addr, 64'h0);
        check_eq("rst_mem_wdata", mem_wdata, 64'h0);
        check_eq("rst_retire", 64'(retire), 64'd0);
        check_eq("rst_halted", 64'(halted), 64'd0);
        check_eq("rst_writedata", writedata, 64'h0);
        @(posedge clock);
        #2 reset_n = 1'b1;
    endtask

    task automatic run_to_halt(input logic [63:0] exp_pc);
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clock);
            if (halted) done = 1'b1;
        end
        check_eq("halt_reached", 64'(halted), 64'd1);
        check_eq("sb_drained", 64'(sb.size()), 64'd0);
        check_eq("stores_drained", 64'(sq.size()), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            #1;
            check_eq("halt_pc", pc, exp_pc);
            check_eq("halt_mem_req", 64'(mem_req), 64'd0);
            check_eq("halt_sticky", 64'(halted), 64'd1);
            check_eq("halt_no_retire", 64'(retire), 64'd0);
        end
    endtask

    initial begin
        reset_n = 1'b0;

        // ALU ops, XZR as destination and source, illegal opcode at 0x20.
        wait_n = 0;
        mem.delete();
        mem[64'hF0] = 64'd5;
        mem[64'hF8] = 64'd7;
        put_ins(64'h00, enc_m(OpcLdur, 5'd2, 5'd31, 9'hF0)); push_ret(64'h04, 64'd5, 5);
        put_ins(64'h04, enc_m(OpcLdur, 5'd3, 5'd31, 9'hF8)); push_ret(64'h08, 64'd7, 5);
        put_ins(64'h08, enc_r(OpcAdd, 5'd1, 5'd2, 5'd3));    push_ret(64'h0C, 64'd12, 4);
        put_ins(64'h0C, enc_r(OpcAdd, 5'd31, 5'd1, 5'd1));  push_ret(64'h10, 64'd24, 4);
        put_ins(64'h10, enc_r(OpcAdd, 5'd6, 5'd31, 5'd1));  push_ret(64'h14, 64'd12, 4);
        put_ins(64'h14, enc_r(OpcSub, 5'd7, 5'd2, 5'd3));    push_ret(64'h18, 64'hFFFF_FFFF_FFFF_FFFE, 4);
        put_ins(64'h18, enc_r(OpcAnd, 5'd8, 5'd1, 5'd3));    push_ret(64'h1C, 64'd4, 4);
        put_ins(64'h1C, enc_r(OpcOrr, 5'd9, 5'd1, 5'd3));    push_ret(64'h20, 64'd15, 4);
        put_ins(64'h20, Illegal);
        do_reset();
        run_to_halt(64'h20);

        // Branches: CBZ taken/not taken at 0x40, B with negative offsets.
        wait_n = 0;
        mem.delete();
        mem[64'hF0] = 64'd1;
        put_ins(64'h00, enc_b(26'h10));               push_ret(64'h40, 64'd0, 3);
        put_ins(64'h40, enc_cbz(5'd5, 19'h7FFFE));    push_ret(64'h38, 64'd0, 3);
        put_ins(64'h38, enc_m(OpcLdur, 5'd5, 5'd31, 9'hF0)); push_ret(64'h3C, 64'd1, 5);
        put_ins(64'h3C, enc_b(26'h1));                push_ret(64'h40, 64'd1, 3);
        push_ret(64'h44, 64'd1, 3);
        put_ins(64'h44, enc_b(26'h3FFFFF3));          push_ret(64'h10, 64'd1, 3);
        put_ins(64'h10, enc_b(26'h3FFFFFF));          push_ret(64'h0C, 64'd1, 3);
        put_ins(64'h0C, Illegal);
        do_reset();
        run_to_halt(64'h0C);

        // Three wait states: reset during a pending fetch, then store/load round trip.
        wait_n = 3;
        mem.delete();
        mem[64'hF0] = 64'd12;
        mem[64'hE8] = 64'h100;
        do_reset();
        @(negedge clock);
        @(negedge clock);
        #1;
        check_eq("fetch_req_pending", 64'(mem_req), 64'd1);
        check_eq("fetch_addr", mem_addr, 64'h0);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check_eq("req_drop_on_reset", 64'(mem_req), 64'd0);
        check_eq("reset_mid_pc", pc, 64'h0);
        check_eq("reset_mid_halted", 64'(halted), 64'd0);
        put_ins(64'h00, enc_m(OpcLdur, 5'd1, 5'd31, 9'hF0)); push_ret(64'h04, 64'd12, 11);
        put_ins(64'h04, enc_m(OpcLdur, 5'd0, 5'd31, 9'hE8)); push_ret(64'h08, 64'h100, 11);
        put_ins(64'h08, enc_m(OpcStur, 5'd1, 5'd0, 9'h008)); push_ret(64'h0C, 64'h100, 10);
        push_store(64'h108, 64'd12);
        put_ins(64'h0C, enc_m(OpcLdur, 5'd4, 5'd0, 9'h008)); push_ret(64'h10, 64'd12, 11);
        put_ins(64'h10, Illegal);
        @(posedge clock);
        @(posedge clock);
        #2 reset_n = 1'b1;
        run_to_halt(64'h10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lgv8_multicycle_core.md
Name: lgv8_multicycle_core

Overview:
- Parametrised multi-cycle LEGv8 core; next generation of the team's single-cycle CPU top.
- Owns its PC, the 32-entry register file and a control FSM.
- Talks to one external unified memory through a req/ready handshake.
- Subset: ADD, SUB, AND, ORR, LDUR, STUR, CBZ, B. Any other opcode halts the core.

Parameters:
- XLEN, 64, datapath, register and address width (must be ≥32, multiple of 8).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clock  input  1  single system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- mem_req  output  1  memory request valid; held until mem_ready.
- mem_we  output  1  1 = write (STUR), 0 = read (fetch or LDUR).
- mem_addr  output  XLEN  byte address.
- mem_wdata  output  XLEN  store data.
- mem_rdata  input  XLEN  read data; instruction fetch uses bits [31:0].
- mem_ready  input  1  completes the current request this cycle.
- pc  output  XLEN  current architectural PC.
- writedata  output  XLEN  value written to the register file on the last writeback.
- retire  output  1  one-cycle pulse when an instruction completes.
- halted  output  1  sticky; set on illegal opcode.

Behaviour:
- Reset (async assert, sync release):
  - state=FETCH, pc=RESET_PC.
  - All registers 0.
  - mem_req, mem_we, retire, halted = 0; writedata=0; mem_addr, mem_wdata = 0.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. On mem_ready, latch ir=mem_rdata[31:0] and go to DECODE.
- DECODE:
  - Latch A=X[ir[9:5]].
  - Latch B=X[ir[20:16]] for R-type, X[ir[4:0]] for STUR/CBZ (reg2loc).
  - Classify opcode; unknown opcode -> HALT.
- EXEC:
  - R-type: ALU result -> WB.
  - LDUR/STUR: addr = A + sext(ir[20:12]) -> MEM.
  - CBZ: if B==0, pc = pc + (sext(ir[23:5])<<2), else pc+4. retire=1; go to FETCH.
  - B: pc = pc + (sext(ir[25:0])<<2). retire=1; go to FETCH.
- MEM:
  - mem_req=1, mem_addr=addr.
  - STUR: mem_we=1, mem_wdata=B. On ready, pc+=4, retire=1, go to FETCH.
  - LDUR: mem_we=0. On ready, latch data and go to WB.
- WB: if rd≠31, X[rd]=result; writedata=result even if rd=31. pc+=4; retire=1; go to FETCH.
- HALT: absorbing until reset. halted=1, mem_req=0; pc holds the offending instruction's address.
- Opcodes:
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 (bits [31:21]).
  - LDUR 11111000010, STUR 11111000000.
  - CBZ 10110100 (bits [31:24]).
  - B 000101 (bits [31:26]).
- Arithmetic: modulo 2^XLEN, no flags. Sign-extension to XLEN. PC wraps modulo 2^XLEN.
- Register 31 is XZR: reads 0, writes discarded.
- Handshake:
  - mem_addr, mem_we and mem_wdata are stable while mem_req=1 and mem_ready=0.
  - mem_ready while mem_req=0 is ignored.
  - A ready in the same cycle as the request completes it (zero-wait).
- Latency with zero-wait memory, FETCH entry to next FETCH entry: R-type 4, LDUR 5, STUR 4, CBZ/B 3. Each wait cycle adds 1.
- Reset asserted mid-request: mem_req drops immediately; the in-flight access is abandoned.

Optional Feature:
- Macro LGV8_PERF_CNT_EN.
- Defined:
  - Adds outputs cycle_cnt[31:0] and instret_cnt[31:0], both reset to 0.
  - cycle_cnt increments every cycle while not halted.
  - instret_cnt increments on each retire.
  - Both wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Zero-wait memory, program ADD X1,X2,X3 with X2=5, X3=7 (preloaded via LDUR) -> X1=12, writedata=12, retire 4 cycles after FETCH entry.
- STUR X1,[X0,#8] then LDUR X4,[X0,#8] with X0=0x100 and mem_ready delayed 3 cycles -> store to addr 0x108; mem_addr and mem_wdata held stable during the wait; X4=12.
- CBZ X5,#-2 with X5=0 at pc=0x40 -> pc=0x38. Same instruction with X5=1 -> pc=0x44.
- B with imm26=0x3FFFFFF at pc=0x10 -> pc=0x0C. ADD XZR,X1,X1 -> no register change, writedata=24.
- Fetch of 0xFFFFFFFF at pc=0x20 -> halted=1, pc=0x20, mem_req=0 forever. reset_n pulsed low mid-FETCH -> pc=RESET_PC, halted=0.
- With LGV8_PERF_CNT_EN defined, run the first test -> instret_cnt=1, cycle_cnt equals the elapsed cycles.
